// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that snoops processor byte stores
// to TX_ADDR into a FIFO and clears its sticky overflow flag on stores to CTRL_ADDR.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
    parameter logic [31:0] CTRL_ADDR    = 32'h0000_0104,
    parameter int          DEPTH        = 8,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [31:0]                ALUResult,
    input  logic [31:0]                WriteData,
    output logic                       tx,
    output logic                       busy,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CKW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [CKW-1:0] CNT_LAST = CKW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]     mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [1:0]     state_q, state_d;
    logic [CKW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;

    logic push_req, push_ok, drop, ctrl_wr, pop, bit_done, empty;
    logic unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign empty    = (count_q == '0);
    assign push_req = MemWrite && (ALUResult == TX_ADDR);
    assign ctrl_wr  = MemWrite && (ALUResult == CTRL_ADDR);
    assign bit_done = (clk_cnt_q == CNT_LAST);
    assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push_ok  = push_req && ((count_q != DEPTH_C) || pop);
    assign drop     = push_req && !push_ok;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (ctrl_wr) ovf_d = 1'b0;
        else if (drop) ovf_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                    shift_d   = mem_q[rd_ptr_q];
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (!empty) begin
                        state_d = S_START;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= WriteData[7:0];
    end

    // tx decodes straight from state so an async reset drives the line high at once.
    always_comb begin
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_q[bit_idx_q];
            default: tx = 1'b1;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign fifo_empty = empty;
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (DEPTH=8, CLKS_PER_BIT=4).
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        tx, busy, fifo_empty, fifo_full, overflow;
    logic [3:0]  fifo_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_bytes [16];

    mmio_uart_tx #(
        .TX_ADDR(32'h0000_0100),
        .CTRL_ADDR(32'h0000_0104),
        .DEPTH(8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .tx(tx),
        .busy(busy),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int i);
        int p;
        p = i / CPB;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".tx"}, tx, 1'b1);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    // Checks frames exp_bytes[0..n-1] from frame cycle c0 on; q = bytes queued after the pushes.
    task automatic check_stream(input int n, input int c0, input int q);
        for (int i = c0; i < n * FRAME; i++) begin
            check("stream.tx", tx, exp_tx(exp_bytes[i / FRAME], i % FRAME));
            check("stream.busy", busy, 1'b1);
            if ((i % FRAME == 0) && (i > 0))
                check("stream.count", fifo_count, q - i / FRAME);
            tick();
        end
        check_idle("stream_end");
        check("stream_end.empty", fifo_empty, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        repeat (3) tick();
        check_idle("rst");
        check("rst.count", fifo_count, 0);
        check("rst.empty", fifo_empty, 1'b1);
        check("rst.full", fifo_full, 1'b0);
        check("rst.ovf", overflow, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 50; i++) begin
            tick();
            check_idle("idle");
            check("idle.empty", fifo_empty, 1'b1);
            check("idle.count", fifo_count, 0);
            check("idle.ovf", overflow, 1'b0);
        end

        // single byte 0x41
        store(32'h100, 32'h0000_0041);
        check("single.count_k", fifo_count, 1);
        check_idle("single_k");
        tick();
        check("single.count_k1", fifo_count, 0);
        exp_bytes[0] = 8'h41;
        check_stream(1, 0, 0);

        // back-to-back 0x55, 0xA3, 0x0F
        store(32'h100, 32'h55);
        check("b2b.count0", fifo_count, 1);
        store(32'h100, 32'hA3);
        check("b2b.count1", fifo_count, 1);
        store(32'h100, 32'h0F);
        check("b2b.count2", fifo_count, 2);
        exp_bytes[0] = 8'h55;
        exp_bytes[1] = 8'hA3;
        exp_bytes[2] = 8'h0F;
        check_stream(3, 1, 2);

        // overflow: 10 stores, only 0..8 survive
        for (int j = 0; j < 10; j++) begin
            store(32'h100, j);
            exp_bytes[j] = 8'(j);
        end
        check("ovf.flag", overflow, 1'b1);
        check("ovf.full", fifo_full, 1'b1);
        check("ovf.count", fifo_count, 8);
        check_stream(9, 8, 8);
        check("ovf.sticky", overflow, 1'b1);
        store(32'h104, 32'hDEAD_BEEF);
        check("ovf.cleared", overflow, 1'b0);
        check("ovf.ctrl_nopush", fifo_count, 0);

        // address filter
        store(32'h0FC, 32'h11);
        store(32'h108, 32'h22);
        ALUResult = 32'h100;
        WriteData = 32'h33;
        tick();
        ALUResult = '0;
        WriteData = '0;
        for (int i = 0; i < 20; i++) begin
            check_idle("filter");
            check("filter.count", fifo_count, 0);
            tick();
        end

        // reset during DATA bit 3 of 0xFF
        store(32'h100, 32'hFF);
        tick();
        repeat (17) tick();
        check("midrst.busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst.empty", fifo_empty, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check_idle("postrst");
            check("postrst.empty", fifo_empty, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped serial output peripheral that sits downstream of the single-cycle processor.
- Snoops the processor's store bus (MemWrite, ALUResult, WriteData) alongside data memory.
- Captures byte stores to a fixed TX address into a small FIFO and transmits them as 8N1 UART frames.
- Gives programs running on the core a console output; a store-to-control address clears the sticky overflow flag.

Parameters:
TX_ADDR, 32'h0000_0100, store address whose WriteData[7:0] is enqueued
CTRL_ADDR, 32'h0000_0104, store address that clears the overflow flag (WriteData ignored)
DEPTH, 8, FIFO entries (power of two, >=2)
CLKS_PER_BIT, 4, clock cycles per UART bit (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemWrite  input  1  processor store strobe
ALUResult  input  32  processor store address
WriteData  input  32  processor store data; only [7:0] used
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is on the line (state != IDLE)
fifo_empty  output  1  FIFO holds 0 entries
fifo_full  output  1  FIFO holds DEPTH entries
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: a TX store was dropped because FIFO was full

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
  - FSM=IDLE; FIFO pointers and bit/clock counters = 0.
  - Mid-frame reset aborts the frame and forces tx high immediately; no partial frame resumes.
- Push:
  - At a clk edge with MemWrite=1 and ALUResult==TX_ADDR, WriteData[7:0] is written at the tail.
  - Accepted if count<DEPTH, or if a pop occurs on the same edge (count unchanged).
  - Otherwise the byte is dropped and overflow is set.
  - Address compare is the full 32 bits; no byte-lane or alignment decoding.
- Overflow clear:
  - MemWrite=1 and ALUResult==CTRL_ADDR clears overflow at that edge.
  - A drop on the same edge cannot occur (addresses differ).
- Pop:
  - Occurs on the edge where the FSM leaves IDLE, or leaves the last STOP cycle, with the FIFO non-empty.
  - The head byte is loaded into the shift register.
  - Push and pop on the same edge: count unchanged.
- FSM states: IDLE, START, DATA, STOP. A clock counter counts 0..CLKS_PER_BIT-1 in each bit period.
  - IDLE: tx=1. If !fifo_empty at an edge, pop and go to START. A byte pushed at edge k is popped at edge k+1, so tx falls after edge k+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[bit_index], LSB first, CLKS_PER_BIT cycles per bit. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle's edge: if !fifo_empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles; busy=1 for all of them.
- Flag timing: fifo_full, fifo_empty, and fifo_count are registered-state-derived; they reflect the edge just taken, with no combinational path from the bus inputs.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked separately, so full and empty are unambiguous.
- Store traffic to other addresses has no effect.
- The block never back-pressures the processor.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no stores for 50 cycles -> tx=1, busy=0, fifo_empty=1, fifo_count=0, overflow=0 throughout.
- Single byte (CLKS_PER_BIT=4): store 0x0000_0041 to 0x100 at edge k -> tx goes low after edge k+1 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop high for 4 cycles. busy high for exactly 40 cycles. fifo_count is 1 after edge k and 0 after edge k+1.
- Back-to-back: store 0x55, 0xA3, 0x0F on three consecutive cycles -> three contiguous 40-cycle frames, each start bit immediately following the previous stop bit. Bytes are received in order 0x55, 0xA3, 0x0F. fifo_count peaks at 2.
- Overflow: store 10 bytes 0x00..0x09 on consecutive cycles (DEPTH=8) -> only 0x00..0x08 are transmitted (one popped early, eight queued) and overflow=1. A later store to 0x104 clears overflow; the next edge shows overflow=0.
- Address filter: stores to 0x0FC and 0x108, and a cycle with MemWrite=0 but ALUResult=0x100 -> no push, tx stays high.
- Reset mid-frame: store 0xFF, assert reset during DATA bit 3 -> tx=1 and busy=0 immediately (before the next clk edge). After release, fifo_empty=1 and no frame resumes.
